// File: rtl/mdc_output_reorder.sv
// Output collector for the radix-4 MDC FFT: digit-reversed 4x8 frame in, natural-order bins out.
// Optional MDC_REORDER_OREG_EN registers the output stream (adds one cycle of first-bin latency).
module mdc_output_reorder #(
    parameter int NB     = 16,
    parameter int NPOINT = 32,
    parameter int LANES  = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rdy_mdc_i,
    input  logic [LANES*NB-1:0] dr_mdc_i,
    input  logic [LANES*NB-1:0] di_mdc_i,
    output logic [NB-1:0]       dr_o,
    output logic [NB-1:0]       di_o,
    output logic [4:0]          idx_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                last_o,
    output logic                ovf_o,
    output logic                err_o
);
    typedef enum logic [1:0] {IDLE, CAP, DROP} cap_e;

    cap_e       st_q, st_d;
    logic [2:0] beat_q, beat_d;
    logic       wbank_q, wbank_d;
    logic       rbank_q, rbank_d;
    logic [1:0] full_q, full_d;
    logic [4:0] rcnt_q, rcnt_d;
    logic       ovf_q, ovf_d;
    logic       err_q, err_d;

    logic       wr_en;
    logic [2:0] wr_beat;
    logic       src_valid;
    logic       src_ready;
    logic       src_acc;
    logic       rel;
    logic       wfree;
    logic       set_full;

    logic [NB-1:0] mem_r [2][NPOINT];
    logic [NB-1:0] mem_i [2][NPOINT];
    logic [NB-1:0] rd_r;
    logic [NB-1:0] rd_i;

    function automatic logic [4:0] bitrev5(input logic [4:0] p);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) begin
            r[i] = p[4-i];
        end
        return r;
    endfunction

    assign src_valid = full_q[rbank_q];
    assign src_acc   = src_valid & src_ready;
    assign rel       = src_acc & (rcnt_q == 5'd31);
    // a bank drained this very cycle may be refilled immediately
    assign wfree     = ~full_q[wbank_q] | (rel & (rbank_q == wbank_q));
    assign rd_r      = mem_r[rbank_q][rcnt_q];
    assign rd_i      = mem_i[rbank_q][rcnt_q];

    always_comb begin
        st_d     = st_q;
        beat_d   = beat_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        wr_en    = 1'b0;
        wr_beat  = beat_q;
        set_full = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (rdy_mdc_i) begin
                    beat_d = 3'd1;
                    if (wfree) begin
                        wr_en   = 1'b1;
                        wr_beat = 3'd0;
                        st_d    = CAP;
                    end else begin
                        ovf_d = 1'b1;
                        st_d  = DROP;
                    end
                end
            end
            CAP: begin
                wr_en  = 1'b1;
                beat_d = beat_q + 3'd1;
                if (rdy_mdc_i) err_d = 1'b1;
                if (beat_q == 3'd7) begin
                    set_full = 1'b1;
                    st_d     = IDLE;
                end
            end
            DROP: begin
                beat_d = beat_q + 3'd1;
                if (rdy_mdc_i) err_d = 1'b1;
                if (beat_q == 3'd7) st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        full_d  = full_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        rcnt_d  = rcnt_q;
        if (src_acc) rcnt_d = rcnt_q + 5'd1;
        if (rel) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
        end
        if (set_full) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q    <= IDLE;
            beat_q  <= 3'd0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            full_q  <= 2'b00;
            rcnt_q  <= 5'd0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            beat_q  <= beat_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            full_q  <= full_d;
            rcnt_q  <= rcnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    // beat c, lane l lands on bin bitrev5({l, c})
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                mem_r[wbank_q][bitrev5({2'(l), wr_beat})] <= dr_mdc_i[l*NB +: NB];
                mem_i[wbank_q][bitrev5({2'(l), wr_beat})] <= di_mdc_i[l*NB +: NB];
            end
        end
    end

    assign ovf_o = ovf_q;
    assign err_o = err_q;

`ifdef MDC_REORDER_OREG_EN
    logic          ov_q, ov_d;
    logic          ol_q, ol_d;
    logic [4:0]    oidx_q, oidx_d;
    logic [NB-1:0] odr_q, odr_d;
    logic [NB-1:0] odi_q, odi_d;

    assign src_ready = ~ov_q | ready_i;

    always_comb begin
        ov_d   = ov_q;
        ol_d   = ol_q;
        oidx_d = oidx_q;
        odr_d  = odr_q;
        odi_d  = odi_q;
        if (src_ready) begin
            ov_d = src_valid;
            if (src_valid) begin
                ol_d   = (rcnt_q == 5'd31);
                oidx_d = rcnt_q;
                odr_d  = rd_r;
                odi_d  = rd_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ov_q   <= 1'b0;
            ol_q   <= 1'b0;
            oidx_q <= 5'd0;
            odr_q  <= '0;
            odi_q  <= '0;
        end else begin
            ov_q   <= ov_d;
            ol_q   <= ol_d;
            oidx_q <= oidx_d;
            odr_q  <= odr_d;
            odi_q  <= odi_d;
        end
    end

    assign valid_o = ov_q;
    assign last_o  = ov_q & ol_q;
    assign idx_o   = oidx_q;
    assign dr_o    = odr_q;
    assign di_o    = odi_q;
`else
    assign src_ready = ready_i;
    assign valid_o   = src_valid;
    assign last_o    = src_valid & (rcnt_q == 5'd31);
    assign idx_o     = rcnt_q;
    assign dr_o      = src_valid ? rd_r : '0;
    assign di_o      = src_valid ? rd_i : '0;
`endif

endmodule

// File: tb/tb_mdc_output_reorder.sv
// Scoreboard bench for mdc_output_reorder: directed MDC-order frames, natural-order bins expected.
module tb_mdc_output_reorder;
    localparam int NB = 16;
    localparam int LN = 4;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             rdy_mdc;
    logic [LN*NB-1:0] dr_mdc;
    logic [LN*NB-1:0] di_mdc;
    logic [NB-1:0]    dr_o;
    logic [NB-1:0]    di_o;
    logic [4:0]       idx_o;
    logic             valid_o;
    logic             ready;
    logic             last_o;
    logic             ovf_o;
    logic             err_o;

    typedef struct packed {
        logic [4:0]    idx;
        logic [NB-1:0] dr;
        logic [NB-1:0] di;
        logic          last;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_fail = 0;

    mdc_output_reorder dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .rdy_mdc_i (rdy_mdc),
        .dr_mdc_i  (dr_mdc),
        .di_mdc_i  (di_mdc),
        .dr_o      (dr_o),
        .di_o      (di_o),
        .idx_o     (idx_o),
        .valid_o   (valid_o),
        .ready_i   (ready),
        .last_o    (last_o),
        .ovf_o     (ovf_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] brev(input logic [4:0] p);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = p[4-i];
        return r;
    endfunction

    // monitor: every accepted output word is checked against the scoreboard
    always @(negedge clk) begin
        if (rst_ni && valid_o && ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_bin: got idx %0d dr %0h, required none", idx_o, dr_o);
            end else begin
                e = sb.pop_front();
                check("bin", 64'({idx_o, dr_o, di_o, last_o}), 64'(e));
            end
        end
    end

    task automatic drive_frame(input int base, input bit push, input bit repulse);
        logic [4:0] k;
        exp_t x;
        if (push) begin
            for (int b = 0; b < 32; b++) begin
                x.idx  = 5'(b);
                x.dr   = 16'(base + b);
                x.di   = 16'(base + b + 32);
                x.last = (b == 31);
                sb.push_back(x);
            end
        end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            rdy_mdc = (c == 0) || (repulse && c == 3);
            for (int l = 0; l < LN; l++) begin
                k = brev(5'(l*8 + c));
                dr_mdc[l*NB +: NB] = 16'(base + int'(k));
                di_mdc[l*NB +: NB] = 16'(base + int'(k) + 32);
            end
        end
    endtask

    task automatic idle_in();
        @(posedge clk);
        #1;
        rdy_mdc = 1'b0;
        dr_mdc  = '0;
        di_mdc  = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni  = 1'b0;
        rdy_mdc = 1'b0;
        dr_mdc  = '0;
        di_mdc  = '0;
        ready   = 1'b0;
        cycles(3);
        check("rst_flags", {valid_o, last_o, ovf_o, err_o}, 0);
        check("rst_data", {idx_o, dr_o, di_o}, 0);
        rst_ni = 1'b1;
        cycles(2);

        // single frame, latency and continuous drain
        ready = 1'b1;
        drive_frame(0, 1, 0);
        check("lat_early", valid_o, 0);
        idle_in();
        check("lat_valid", valid_o, 1);
        check("first_bin", {idx_o, dr_o, di_o}, {5'd0, 16'd0, 16'd32});
        cycles(32);
        check("t1_done", valid_o, 0);
        check("t1_sb", sb.size(), 0);

        // backpressure: ready toggling
        ready = 1'b0;
        drive_frame(100, 1, 0);
        idle_in();
        for (int i = 0; i < 64; i++) begin
            ready = ~i[0];
            @(posedge clk);
            #1;
        end
        ready = 1'b0;
        check("bp_done", valid_o, 0);
        check("bp_sb", sb.size(), 0);

        // ping-pong back-to-back frames
        ready = 1'b1;
        drive_frame(200, 1, 0);
        drive_frame(300, 1, 0);
        idle_in();
        cycles(24);
        check("pp_seam", {valid_o, idx_o, dr_o}, {1'b1, 5'd0, 16'd300});
        cycles(32);
        check("pp_done", valid_o, 0);
        check("pp_sb", sb.size(), 0);
        check("pp_ovf", ovf_o, 0);

        // overflow: third frame dropped
        ready = 1'b0;
        drive_frame(400, 1, 0);
        drive_frame(500, 1, 0);
        check("ovf_before", ovf_o, 0);
        drive_frame(600, 0, 0);
        check("ovf_set", ovf_o, 1);
        idle_in();
        ready = 1'b1;
        cycles(64);
        check("ovf_done", valid_o, 0);
        check("ovf_sb", sb.size(), 0);

        // protocol error: rdy re-pulsed on beat 3
        check("err_before", err_o, 0);
        drive_frame(700, 1, 1);
        idle_in();
        check("err_set", err_o, 1);
        cycles(32);
        check("err_done", valid_o, 0);
        check("err_sb", sb.size(), 0);

        // reset while bin 10 is on the output
        drive_frame(800, 1, 0);
        idle_in();
        cycles(10);
        check("rst_bin10", {valid_o, idx_o, dr_o}, {1'b1, 5'd10, 16'd810});
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_async", {valid_o, last_o, ovf_o, err_o}, 0);
        sb.delete();
        cycles(2);
        rst_ni = 1'b1;
        cycles(1);
        drive_frame(900, 1, 0);
        idle_in();
        check("post_rst_valid", {valid_o, idx_o, dr_o}, {1'b1, 5'd0, 16'd900});
        cycles(32);
        check("post_rst_done", valid_o, 0);
        check("post_rst_sb", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mdc_output_reorder.md
Name: mdc_output_reorder

Overview:
- Collector at the output of the radix-4 MDC FFT core. It captures one 32-point frame delivered as 4 lanes × 8 beats in digit-reversed order.
- Frames are buffered in a ping-pong pair of banks.
- Bins are emitted serially in natural order (bin 0..31) over a valid/ready stream, for the downstream serial consumer or the bench checker.

Parameters:
- NB, 16, width of one real or imaginary sfp word
- NPOINT, 32, frame length; fixed at 32 for this revision (5-bit bin index)
- LANES, 4, parallel lanes per input beat

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- rdy_mdc_i  input  1  one-cycle pulse marking beat 0 of a frame; beats 1..7 follow on consecutive cycles
- dr_mdc_i  input  LANES*NB  real lanes; lane l occupies bits [l*NB +: NB]
- di_mdc_i  input  LANES*NB  imaginary lanes, same packing
- dr_o  output  NB  real part of current bin
- di_o  output  NB  imaginary part of current bin
- idx_o  output  5  bin index of current output
- valid_o  output  1  output word valid
- ready_i  input  1  downstream accept
- last_o  output  1  high with bin 31
- ovf_o  output  1  sticky: frame dropped because both banks were full
- err_o  output  1  sticky: rdy_mdc_i seen while a capture was still in progress

Behaviour:
- Reset: all outputs 0; both banks empty; write and read pointers 0; capture FSM IDLE. Bank contents are not reset.
- Mapping on capture beat c (0..7), lane l: position p = l*8 + c; word stored at bin address k = bitrev5(p).
- Capture FSM: IDLE -> CAP on rdy_mdc_i, which also writes beat 0. CAP counts beats 1..7, then returns to IDLE and marks the bank full. A frame therefore occupies 8 consecutive cycles with no gaps.
- Bank select at rdy_mdc_i:
  - Take the free bank; the write bank toggles per accepted frame.
  - If both banks are full, the whole frame is dropped, ovf_o is set and FSM enters DROP for 8 cycles.
  - A bank released in the same cycle as rdy_mdc_i counts as free.
- rdy_mdc_i while in CAP or DROP: ignored, err_o set, current capture continues unaffected.
- Read FSM:
  - When the read bank is full, valid_o = 1 with idx_o = read counter, and dr_o/di_o = bank[idx_o] read combinationally.
  - On valid_o & ready_i the counter increments.
  - At bin 31 with last_o = 1, accept releases the bank, the counter wraps to 0 and the read bank toggles.
- Latency: beat 0 at cycle T -> valid_o with bin 0 at T+8 (last beat written T+7). Back-to-back frames with ready_i held 1 stream continuously, 32 bins per 8 input cycles max rate; a sustained input rate above one frame per 32 cycles overflows.
- valid_o, once high, stays high and the data holds stable until accepted (AXI-style). ready_i is not allowed to affect valid_o.
- Reading and writing the two different banks in the same cycle is always legal. The same bank is never read and written simultaneously by construction.
- Reset asserted mid-frame: capture is abandoned, both banks are emptied, and valid_o drops asynchronously.

Optional Feature:
- Macro MDC_REORDER_OREG_EN.
- Defined: an output register (one-entry skid buffer) sits on dr_o/di_o/idx_o/last_o/valid_o. First-bin latency becomes T+9. Full throughput is retained under ready_i toggling, and outputs are driven directly from flops.
- Undefined: combinational bank read path, latency T+8.

Test Plan:
- Single frame: bank word at bin k = {real=k, imag=k+32}, driven in MDC order (beat c, lane l carries bin bitrev5(l*8+c)), ready_i = 1 -> valid_o at T+8, idx_o/dr_o = 0..31 natural order, di_o = 32..63, last_o only at bin 31, 32 consecutive valid cycles.
- Backpressure: ready_i toggles 1,0,1,0 -> each bin is held stable while ready_i = 0, no bin skipped or duplicated, 64 cycles to drain.
- Ping-pong: two frames 8 cycles apart, ready_i = 1 -> 64 bins in order, frame 2 bin 0 immediately after frame 1 bin 31, ovf_o = 0.
- Overflow: ready_i = 0, three frames back-to-back -> ovf_o = 1 at third rdy_mdc_i; after ready_i = 1 only frames 1 and 2 emerge.
- Protocol error: rdy_mdc_i re-pulsed at beat 3 -> err_o = 1, frame still captured and emitted intact.
- Reset mid-stream: rst_ni low during bin 10 of output -> valid_o = 0 immediately, all flags 0; new frame after release is emitted correctly from bin 0.
